// File: rtl/imem_loader_arb.sv
// IMEM port-A write arbiter: CPU stores pass straight through, a byte-stream loader packs
// little-endian words and writes them when the port is free. Optional macro: IMEM_LOADER_CKSUM_EN.
module imem_loader_arb #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [XLEN-1:0]       cpu_din,
    input  logic                  ld_start,
    input  logic [ADDR_WIDTH-1:0] ld_base,
    input  logic [ADDR_WIDTH:0]   ld_len,
    input  logic                  ld_byte_valid,
    input  logic [7:0]            ld_byte,
    output logic                  ld_byte_ready,
    output logic                  ld_busy,
    output logic                  ld_done,
    output logic [XLEN-1:0]       ld_checksum,
    output logic [ADDR_WIDTH-1:0] imem_adra,
    output logic [XLEN-1:0]       imem_dina,
    output logic [3:0]            imem_wea
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [1:0]              idx_q;
    logic [XLEN-1:0]         buf_q;
    logic                    rdy_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    cpu_act_c;

    assign cpu_act_c = (cpu_we != 4'b0000);

    // Loader FSM; a CPU store in WRITE simply holds every register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_start) begin
                        addr_q <= ld_base;
                        cnt_q  <= ld_len;
                        idx_q  <= '0;
                        if (ld_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= FILL;
                            rdy_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (ld_byte_valid) begin
                        buf_q[{idx_q, 3'b000} +: 8] <= ld_byte;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= WRITE;
                            rdy_q   <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (!cpu_act_c) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        cnt_q  <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FILL;
                            rdy_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CKSUM_EN
    logic [XLEN-1:0] cksum_q;

    // Word sum of the current load, cleared by every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cksum_q <= '0;
        end else if (state_q == IDLE && ld_start) begin
            cksum_q <= '0;
        end else if (state_q == WRITE && !cpu_act_c) begin
            cksum_q <= cksum_q + buf_q;
        end
    end

    assign ld_checksum = cksum_q;
`else
    assign ld_checksum = '0;
`endif

    // Port A mux: CPU always wins, loader writes only from WRITE.
    always_comb begin
        imem_adra = addr_q;
        imem_dina = buf_q;
        imem_wea  = 4'b0000;
        if (cpu_act_c) begin
            imem_adra = cpu_addr;
            imem_dina = cpu_din;
            imem_wea  = cpu_we;
        end else if (state_q == WRITE) begin
            imem_wea = 4'b1111;
        end
    end

    assign ld_byte_ready = rdy_q;
    assign ld_busy       = busy_q;
    assign ld_done       = done_q;

endmodule

// File: tb/tb_imem_loader_arb.sv
// Scoreboard bench for imem_loader_arb: drivers queue expected port writes and done pulses,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_imem_loader_arb;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    cpu_we = '0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_din = '0;
    logic          ld_start = 1'b0;
    logic [AW-1:0] ld_base = '0;
    logic [AW:0]   ld_len = '0;
    logic          ld_byte_valid = 1'b0;
    logic [7:0]    ld_byte = '0;
    logic          ld_byte_ready, ld_busy, ld_done;
    logic [31:0]   ld_checksum;
    logic [AW-1:0] imem_adra;
    logic [31:0]   imem_dina;
    logic [3:0]    imem_wea;

    imem_loader_arb #(.ADDR_WIDTH(AW), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
        .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte),
        .ld_byte_ready(ld_byte_ready), .ld_busy(ld_busy), .ld_done(ld_done),
        .ld_checksum(ld_checksum),
        .imem_adra(imem_adra), .imem_dina(imem_dina), .imem_wea(imem_wea)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    we;
        int            gap;
    } wr_t;

    typedef struct {
        logic [31:0] cksum;
        bit          chk_gap;
    } done_t;

    wr_t   wr_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_wr_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_ck(input logic [31:0] v);
`ifdef IMEM_LOADER_CKSUM_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] we, input int gap);
        wr_t e;
        e.addr = a; e.data = d; e.we = we; e.gap = gap;
        wr_q.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] ck, input bit g);
        done_t e;
        e.cksum = exp_ck(ck); e.chk_gap = g;
        done_q.push_back(e);
    endtask

    // Monitor: every port write and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_wea != 4'b0000) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write addr=%h data=%h we=%b", imem_adra, imem_dina, imem_wea);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(imem_adra), 32'(e.addr));
                    chk("wr_data", imem_dina, e.data);
                    chk("wr_we", 32'(imem_wea), 32'(e.we));
                    chk("wr_ready_low", 32'(ld_byte_ready), 32'd0);
                    if (e.gap != 0) chk("wr_gap", 32'(cyc - last_wr_cyc), 32'(e.gap));
                end
                last_wr_cyc = cyc;
            end
            if (ld_done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_cksum", ld_checksum, d.cksum);
                    chk("done_busy_low", 32'(ld_busy), 32'd0);
                    if (d.chk_gap) chk("done_gap", 32'(cyc - last_wr_cyc), 32'd1);
                end
            end
        end
    end

    // All drivers operate 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] len);
        ld_start = 1'b1; ld_base = base; ld_len = len;
        tick();
        ld_start = 1'b0;
        if (len != 0) begin
            chk("start_busy", 32'(ld_busy), 32'd1);
            chk("start_ready", 32'(ld_byte_ready), 32'd1);
        end
    endtask

    task automatic send_bytes(input logic [7:0] b[], input int n);
        for (int i = 0; i < n; i++) begin
            bit ok;
            ok = 1'b0;
            ld_byte_valid = 1'b1;
            ld_byte = b[i];
            for (int t = 0; t < 50 && !ok; t++) begin
                ok = ld_byte_ready;
                tick();
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL byte_timeout actual=no_ready expected=ready byte=%0d", i);
            end
        end
        ld_byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (ld_busy && t < 100) begin
            tick();
            t++;
        end
        if (ld_busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=busy expected=idle");
        end
        tick();
    endtask

    initial begin
        logic [7:0] bytes[];

        // Reset with a stray byte pulse; nothing may be accepted.
        ld_byte_valid = 1'b1;
        ld_byte = 8'hAA;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", 32'(ld_byte_ready), 32'd0);
        chk("rst_busy", 32'(ld_busy), 32'd0);
        chk("rst_done", 32'(ld_done), 32'd0);
        chk("rst_wea", 32'(imem_wea), 32'd0);
        chk("rst_adra", 32'(imem_adra), 32'd0);
        chk("rst_dina", imem_dina, 32'd0);
        chk("rst_cksum", ld_checksum, 32'd0);
        tick();
        ld_byte_valid = 1'b0;
        chk("idle_ignores_byte", 32'(ld_busy), 32'd0);
        tick();

        // Two-word load, valid held high.
        push_wr(14'h010, 32'h00100513, 4'b1111, 0);
        push_wr(14'h011, 32'h00200593, 4'b1111, 5);
        push_done(32'h00300AA6, 1'b1);
        start_load(14'h010, 15'd2);
        bytes = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_bytes(bytes, 8);
        wait_idle();

        // CPU conflict for 3 cycles while a word is pending.
        push_wr(14'h020, 32'hDEADBEEF, 4'b0011, 0);
        push_wr(14'h020, 32'hDEADBEEF, 4'b0011, 1);
        push_wr(14'h020, 32'hDEADBEEF, 4'b0011, 1);
        push_wr(14'h030, 32'h00000013, 4'b1111, 1);
        push_done(32'h00000013, 1'b1);
        start_load(14'h030, 15'd1);
        bytes = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_bytes(bytes, 4);
        cpu_we = 4'b0011; cpu_addr = 14'h020; cpu_din = 32'hDEADBEEF;
        tick(); tick(); tick();
        cpu_we = 4'b0000;
        chk("conflict_still_busy", 32'(ld_busy), 32'd1);
        wait_idle();

        // Zero length: done next cycle, never busy.
        push_done(32'h0, 1'b0);
        start_load(14'h100, 15'd0);
        chk("zero_done", 32'(ld_done), 32'd1);
        chk("zero_busy", 32'(ld_busy), 32'd0);
        tick();
        chk("zero_done_pulse", 32'(ld_done), 32'd0);
        chk("zero_busy_after", 32'(ld_busy), 32'd0);

        // Address wrap at the top of IMEM.
        push_wr(14'h3FFF, 32'h11223344, 4'b1111, 0);
        push_wr(14'h0000, 32'hAABBCCDD, 4'b1111, 5);
        push_done(32'hBBDE0021, 1'b1);
        start_load(14'h3FFF, 15'd2);
        bytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        send_bytes(bytes, 8);
        wait_idle();

        // Reset after two bytes: no write, no done; fresh load packs from byte 0.
        start_load(14'h040, 15'd1);
        bytes = '{8'hEE, 8'hFF};
        send_bytes(bytes, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(ld_busy), 32'd0);
        chk("midrst_ready", 32'(ld_byte_ready), 32'd0);
        chk("midrst_cksum", ld_checksum, 32'd0);
        tick(); tick();
        push_wr(14'h041, 32'h12345678, 4'b1111, 0);
        push_done(32'h12345678, 1'b1);
        start_load(14'h041, 15'd1);
        bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
        send_bytes(bytes, 4);
        wait_idle();

        tick(); tick();
        chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
